load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles waiting for i_mem_ack (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 i_clk  in  1  clock, rising edge.
REQ-004 i_rst  in  1  asynchronous active-high reset.
REQ-005 i_valid  in  1  request from address stage.
REQ-006 o_ready  out  1  request accepted when i_valid & o_ready.
REQ-007 i_op_code  in  4  0000 LB, 0001 LH, 0010 LW, 0011 LBU, 0100 LHU, 1000 SB, 1001 SH, 1010 SW.
REQ-008 i_eff_addr  in  32  effective byte address.
REQ-009 i_store_data  in  32  store source (low bits used for SB/SH).
REQ-010 o_mem_req, o_mem_we  out  1 each  memory request, write enable.
REQ-011 o_mem_addr  out  32  word address (bits[1:0] = 00).
REQ-012 o_mem_be  out  4  byte enables; o_mem_wdata  out  32  lane-steered store data.
REQ-013 i_mem_ack  in  1; i_mem_rdata  in  32  memory response.
REQ-014 o_done  out  1  one-cycle completion pulse; o_load_data  out  32  valid with o_done for loads.
REQ-015 o_exception  out  2  valid with o_done: 00 none, 01 misaligned load, 10 misaligned store, 11 timeout.

Function
REQ-016 States SHALL be IDLE, REQ, DONE; o_ready = 1 only in IDLE.
REQ-017 IDLE: on accept, latch op/addr/data; aligned -> REQ; misaligned or undefined op -> DONE with no memory access.
REQ-018 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00. Undefined op -> exception 00, o_load_data 0.
REQ-019 REQ: o_mem_req held 1 with stable addr/be/wdata/we until i_mem_ack sampled 1 (ack in first REQ cycle valid); then -> DONE, capture i_mem_rdata.
REQ-020 DONE: o_done = 1 for exactly one cycle, then IDLE; minimum accept-to-o_done latency 2 cycles for aligned ops (ack in first REQ cycle), 1 cycle for misaligned.
REQ-021 Little-endian lanes: SB be = 0001 << addr[1:0], wdata = {4{data[7:0]}}; SH be = 0011 << (2*addr[1]), wdata = {2{data[15:0]}}; SW be = 1111; loads be = 1111, we = 0.
REQ-022 Loads SHALL extract byte/half at addr[1:0] from captured rdata; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-023 i_valid while not IDLE SHALL be ignored; i_mem_ack outside REQ SHALL be ignored.
REQ-024 Stores SHALL drive o_load_data = 0 at o_done.

Reset
REQ-025 i_rst SHALL immediately force IDLE, o_ready 1, o_mem_req/o_mem_we/o_done 0, o_mem_addr/o_mem_be/o_mem_wdata/o_load_data 0, o_exception 00.
REQ-026 Reset mid-REQ SHALL drop o_mem_req asynchronously; the request is abandoned, no o_done produced.

Configuration
REQ-027 With LSU_TIMEOUT_EN defined: counter clears on REQ entry; if ack absent for TIMEOUT_CYCLES cycles in REQ, drop o_mem_req, -> DONE with exception 11.
REQ-028 Without LSU_TIMEOUT_EN: no counter; REQ waits indefinitely; exception 11 never produced.

Structure
REQ-029 Package lsu_pkg SHALL hold op-code constants, exception codes, state encoding.
REQ-030 Combinational sub-module lsu_lane_align SHALL compute be, wdata and load extract/extend; FSM and registers live in load_store_unit.

Verification
REQ-031 LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> o_mem_addr 0x100, be 1111, o_done with load_data 0xDEADBEEF, exception 00.
REQ-032 LB addr 0x103, rdata 0x80000000 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x202, data 0x1234ABCD -> be 1100, wdata 0xABCDABCD, we 1, o_done exception 00.
REQ-034 SW addr 0x301 -> no o_mem_req, o_done next cycle, exception 10; LH addr 0x101 -> exception 01.
REQ-035 LSU_TIMEOUT_EN, TIMEOUT_CYCLES 16, ack never -> req drops after 16 REQ cycles, exception 11; without macro req stays high.
REQ-036 i_rst pulsed during REQ -> o_mem_req 0 same cycle, no o_done, next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: op-code constants, exception codes, FSM state encoding and decode helpers for load_store_unit.
package lsu_pkg;
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_LOAD    = 2'b01;
    localparam logic [1:0] EXC_STORE   = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic [1:0] align_exc(input logic [3:0] op, input logic [1:0] a);
        logic mis;
        mis = (op inside {OP_LH, OP_LHU, OP_SH} && a[0]) || (op inside {OP_LW, OP_SW} && a != 2'b00);
        return !mis ? EXC_NONE : is_store(op) ? EXC_STORE : EXC_LOAD;
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian byte-enable and store-data steering, plus load byte/half extract and extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        byte_v = 8'(rdata >> {addr_lo, 3'b000});
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be = op == OP_SB ? 4'b0001 << addr_lo :
             op == OP_SH ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
        wdata = op == OP_SB ? {4{store_data[7:0]}} :
                op == OP_SH ? {2{store_data[15:0]}} :
                op == OP_SW ? store_data : '0;
        load_data = op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                    op == OP_LBU ? {24'h0, byte_v} :
                    op == OP_LH  ? {{16{half_v[15]}}, half_v} :
                    op == OP_LHU ? {16'h0, half_v} :
                    op == OP_LW  ? rdata : '0;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer (IDLE -> REQ -> DONE).
// Define LSU_TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES cycles without ack (exception 11).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_op_code,
    input  logic [31:0] i_eff_addr,
    input  logic [31:0] i_store_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic [1:0]  o_exception
);
    state_t      state, state_n;
    logic [3:0]  op_q;
    logic [31:0] addr_q, data_q, rdata_q;
    logic [1:0]  exc_q, exc_n;
    logic [3:0]  be;
    logic [31:0] wdata, ld;
    logic        timeout_hit;
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // Held at zero outside REQ, so it is already clear on REQ entry.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt <= '0;
        else cnt <= state == S_REQ ? cnt + 1'b1 : '0;
    assign timeout_hit = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout_hit = 1'b0;
`endif
    always_comb begin
        state_n = state;
        exc_n   = exc_q;
        unique case (state)
            S_IDLE: if (i_valid) begin
                exc_n   = align_exc(i_op_code, i_eff_addr[1:0]);
                state_n = (exc_n != EXC_NONE || !(is_load(i_op_code) || is_store(i_op_code))) ? S_DONE : S_REQ;
            end
            S_REQ: if (i_mem_ack) state_n = S_DONE;
                   else if (timeout_hit) begin
                       state_n = S_DONE;
                       exc_n   = EXC_TIMEOUT;
                   end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            exc_q   <= EXC_NONE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            exc_q <= exc_n;
            if (state == S_IDLE && i_valid) begin
                op_q   <= i_op_code;
                addr_q <= i_eff_addr;
                data_q <= i_store_data;
            end
            if (state == S_REQ && i_mem_ack) rdata_q <= i_mem_rdata;
        end
    end
    lsu_lane_align u_align (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .store_data(data_q),
        .rdata     (rdata_q),
        .be        (be),
        .wdata     (wdata),
        .load_data (ld)
    );
    assign o_ready     = state == S_IDLE;
    assign o_mem_req   = state == S_REQ;
    assign o_mem_we    = o_mem_req && is_store(op_q);
    assign o_mem_addr  = {addr_q[31:2], 2'b00};
    assign o_mem_be    = o_mem_req ? be : '0;
    assign o_mem_wdata = o_mem_req ? wdata : '0;
    assign o_done      = state == S_DONE;
    assign o_load_data = (o_done && exc_q == EXC_NONE) ? ld : '0;
    assign o_exception = o_done ? exc_q : EXC_NONE;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench; expected completions are queued at accept and checked on o_done.
module tb_load_store_unit;
    logic        i_clk = 0, i_rst = 1, i_valid = 0, i_mem_ack = 0;
    logic [3:0]  i_op_code = 0;
    logic [31:0] i_eff_addr = 0, i_store_data = 0, i_mem_rdata = 0;
    logic        o_ready, o_mem_req, o_mem_we, o_done;
    logic [31:0] o_mem_addr, o_mem_wdata, o_load_data;
    logic [3:0]  o_mem_be;
    logic [1:0]  o_exception;
    int total = 0, bad = 0, n;
    logic [33:0] sb[$];
    logic [33:0] e;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op_code(i_op_code), .i_eff_addr(i_eff_addr), .i_store_data(i_store_data),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_done(o_done), .o_load_data(o_load_data),
        .o_exception(o_exception)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) if (o_done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
            e = sb.pop_front();
            chk("load_data", o_load_data, e[31:0]);
            chk("exception", {30'h0, o_exception}, {30'h0, e[33:32]});
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, data, input int delay,
                         input logic [31:0] rdata, input logic mem, input logic [3:0] xbe,
                         input logic [31:0] xwd, xld, input logic [1:0] xexc);
        @(negedge i_clk);
        chk("ready", o_ready, 1);
        i_valid = 1; i_op_code = op; i_eff_addr = addr; i_store_data = data;
        sb.push_back({xexc, xld});
        @(negedge i_clk);
        i_valid = 0;
        if (!mem) begin
            chk("no_req", o_mem_req, 0);
            chk("lat1_done", o_done, 1);
        end else begin
            for (int i = 0; i <= delay; i++) begin
                chk("req", o_mem_req, 1);
                chk("addr", o_mem_addr, {addr[31:2], 2'b00});
                chk("be", o_mem_be, xbe);
                chk("we", o_mem_we, op[3]);
                chk("wdata", o_mem_wdata, xwd);
                // new requests while busy must not disturb the outstanding one
                i_valid = i < delay; i_op_code = 4'b1000; i_eff_addr = 32'hFFFF_FFFF;
                i_mem_ack = i == delay; i_mem_rdata = rdata;
                @(negedge i_clk);
            end
            i_mem_ack = 0; i_valid = 0; i_mem_rdata = 32'h0BAD_0BAD;
            chk("done_after_ack", o_done, 1);
        end
        @(negedge i_clk);
        chk("done_pulse", o_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_req", o_mem_req, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_be", {28'h0, o_mem_be}, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_ld", o_load_data, 0);
        chk("rst_exc", {30'h0, o_exception}, 0);
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 0;
        do_op(4'b0010, 32'h100, 0, 3, 32'hDEADBEEF, 1, 4'b1111, 0, 32'hDEADBEEF, 2'b00);
        do_op(4'b0000, 32'h103, 0, 0, 32'h80000000, 1, 4'b1111, 0, 32'hFFFFFF80, 2'b00);
        do_op(4'b0011, 32'h103, 0, 1, 32'h80000000, 1, 4'b1111, 0, 32'h00000080, 2'b00);
        do_op(4'b0001, 32'h102, 0, 0, 32'h80011234, 1, 4'b1111, 0, 32'hFFFF8001, 2'b00);
        do_op(4'b0100, 32'h100, 0, 2, 32'h0000F00F, 1, 4'b1111, 0, 32'h0000F00F, 2'b00);
        do_op(4'b1001, 32'h202, 32'h1234ABCD, 0, 0, 1, 4'b1100, 32'hABCDABCD, 0, 2'b00);
        do_op(4'b1000, 32'h101, 32'h00000055, 1, 0, 1, 4'b0010, 32'h55555555, 0, 2'b00);
        do_op(4'b1010, 32'h300, 32'hCAFEF00D, 0, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 2'b00);
        do_op(4'b1010, 32'h301, 32'h1, 0, 0, 0, 0, 0, 0, 2'b10);
        do_op(4'b0001, 32'h101, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        do_op(4'b0010, 32'h102, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        do_op(4'b0111, 32'h100, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        // stray ack in IDLE
        @(negedge i_clk); i_mem_ack = 1;
        @(negedge i_clk); i_mem_ack = 0;
        chk("ack_idle_ready", o_ready, 1);
        // request with no ack
        @(negedge i_clk);
        i_valid = 1; i_op_code = 4'b0010; i_eff_addr = 32'h400;
`ifdef LSU_TIMEOUT_EN
        sb.push_back({2'b11, 32'h0});
`endif
        @(negedge i_clk);
        i_valid = 0; n = 0;
        while (o_mem_req && n < 40) begin n++; @(negedge i_clk); end
`ifdef LSU_TIMEOUT_EN
        chk("timeout_cycles", n, 16);
        chk("timeout_done", o_done, 1);
`else
        chk("no_timeout", n, 40);
        chk("req_held", o_mem_req, 1);
`endif
        // async reset in REQ
        @(negedge i_clk);
        i_valid = 1; i_op_code = 4'b0010; i_eff_addr = 32'h500;
        @(negedge i_clk);
        i_valid = 0;
        chk("pre_rst_req", o_mem_req, 1);
        #2 i_rst = 1;
        #1 chk("async_req_drop", o_mem_req, 0);
        chk("async_ready", o_ready, 1);
        @(negedge i_clk); i_rst = 0;
        repeat (2) @(negedge i_clk);
        do_op(4'b0010, 32'h104, 0, 1, 32'h01234567, 1, 4'b1111, 0, 32'h01234567, 2'b00);
        repeat (3) @(negedge i_clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
